// File: rtl/serial_op_pkg.sv
// Shared definitions for the bit-serial AND/OR unit and its issuer: state encoding and timing defaults.
// Latency: none (package). Backpressure: n/a.
// Flow control: n/a.
package serial_op_pkg;

   localparam int WIDTH_DEF   = 4;
   localparam int SERIAL_LAT  = 15;
   localparam int TIMEOUT_DEF = 31;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } issuer_state_t;

endpackage

// File: rtl/op_fifo.sv
// Synchronous FIFO holding operand pairs; head entry is visible combinationally on rdata.
// Latency: a push is visible at the head one cycle later. Backpressure: push ignored when full, pop ignored when empty.
module op_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   // Pointers wrap naturally; the extra count bit distinguishes full from empty.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == FULL_CNT);
   assign empty = (count == '0);

endmodule

// File: rtl/serial_op_issuer.sv
// Issues buffered operand pairs one at a time to the bit-serial unit with a watchdog; ISSUER_STATS_EN adds op/timeout counters.
// Latency: pair accepted at edge N pops at N+1, s high the following cycle; result valid the cycle after done_in.
// Backpressure: in_ready = FIFO not full; a result waiting on res_ready blocks further issue.
module serial_op_issuer
   import serial_op_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic             s,
   output logic [WIDTH-1:0] Ain,
   output logic [WIDTH-1:0] Bin,
   input  logic             done_in,
   input  logic [WIDTH-1:0] C_in,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [WIDTH-1:0] res_data,
   output logic             busy,
   output logic             timeout_err
`ifdef ISSUER_STATS_EN
   ,
   output logic [7:0]       op_count,
   output logic [7:0]       timeout_count
`endif
);

   localparam int              WDW     = $clog2(TIMEOUT + 1);
   localparam logic [WDW-1:0]  WD_LAST = WDW'(TIMEOUT - 1);
   localparam int              CW      = $clog2(DEPTH) + 1;

   issuer_state_t    state, state_nxt;
   logic [WDW-1:0]   watchdog, wd_nxt;
   logic             s_nxt, res_valid_nxt, terr_nxt;
   logic [WIDTH-1:0] ain_nxt, bin_nxt, res_data_nxt;

   logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [2*WIDTH-1:0] fifo_head;
   logic [CW-1:0]    fifo_count;
   logic             unused_fifo_count;

   assign fifo_push         = in_valid && in_ready;
   assign in_ready          = !fifo_full;
   assign unused_fifo_count = ^fifo_count;

   op_fifo #(
      .W     (2*WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .wdata ({in_a, in_b}),
      .pop   (fifo_pop),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // done_in wins over watchdog expiry when both land in the same WAIT cycle.
   always_comb begin
      state_nxt     = state;
      fifo_pop      = 1'b0;
      s_nxt         = 1'b0;
      ain_nxt       = Ain;
      bin_nxt       = Bin;
      wd_nxt        = watchdog;
      res_valid_nxt = res_valid;
      res_data_nxt  = res_data;
      terr_nxt      = timeout_err;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               ain_nxt   = fifo_head[2*WIDTH-1:WIDTH];
               bin_nxt   = fifo_head[WIDTH-1:0];
               s_nxt     = 1'b1;
               wd_nxt    = '0;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            wd_nxt    = '0;
            state_nxt = WAIT;
         end
         WAIT: begin
            if (done_in) begin
               res_data_nxt  = C_in;
               res_valid_nxt = 1'b1;
               state_nxt     = HOLD;
            end else if (watchdog == WD_LAST) begin
               terr_nxt  = 1'b1;
               state_nxt = IDLE;
            end else begin
               wd_nxt = watchdog + 1'b1;
            end
         end
         HOLD: begin
            if (res_ready) begin
               res_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         s           <= 1'b0;
         Ain         <= '0;
         Bin         <= '0;
         watchdog    <= '0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
      end else begin
         s           <= s_nxt;
         Ain         <= ain_nxt;
         Bin         <= bin_nxt;
         watchdog    <= wd_nxt;
         res_valid   <= res_valid_nxt;
         res_data    <= res_data_nxt;
         timeout_err <= terr_nxt;
         busy        <= (state_nxt != IDLE);
      end
   end

`ifdef ISSUER_STATS_EN
   logic op_done, op_abort;

   assign op_done  = (state == HOLD) && res_ready;
   assign op_abort = (state == WAIT) && !done_in && (watchdog == WD_LAST);

   // op_count wraps; timeout_count saturates so a stuck unit stays visible.
   always_ff @(posedge clk) begin
      if (reset) begin
         op_count      <= '0;
         timeout_count <= '0;
      end else begin
         if (op_done) op_count <= op_count + 8'd1;
         if (op_abort && (timeout_count != 8'hFF)) timeout_count <= timeout_count + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_serial_op_issuer.sv
// Scoreboard bench for serial_op_issuer with a behavioural serial-unit stub.
module tb_serial_op_issuer;
   import serial_op_pkg::*;

   localparam int W  = 4;
   localparam int D  = 4;
   localparam int TO = 31;
   localparam int M_NORM  = 0;
   localparam int M_EXACT = 1;
   localparam int M_NEVER = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         s;
   logic [W-1:0] Ain, Bin;
   logic         done_in = 1'b0;
   logic [W-1:0] C_in = '0;
   logic         res_valid;
   logic         res_ready = 1'b1;
   logic [W-1:0] res_data;
   logic         busy;
   logic         timeout_err;
`ifdef ISSUER_STATS_EN
   logic [7:0]   op_count, timeout_count;
`endif

   int           n_checks = 0;
   int           n_fail = 0;
   int           rst_gen = 0;
   logic [W-1:0] exp_q[$];
   int           mode_q[$];

   serial_op_issuer #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .s           (s),
      .Ain         (Ain),
      .Bin         (Bin),
      .done_in     (done_in),
      .C_in        (C_in),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .busy        (busy),
      .timeout_err (timeout_err)
`ifdef ISSUER_STATS_EN
      ,
      .op_count      (op_count),
      .timeout_count (timeout_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] stub_c(input logic [W-1:0] a, input logic [W-1:0] b);
      return a ^ b ^ 4'h7;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input bit expect_res);
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      while (!in_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      check("push_accept", in_ready, 1);
      if (in_ready) begin
         @(posedge clk);
         if (expect_res) exp_q.push_back(stub_c(a, b));
         #1 in_valid = 1'b0;
      end else begin
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_s(input int budget);
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (s !== 1'b1 && t < budget);
      check("s_seen", s, 1);
   endtask

   task automatic wait_idle(input int budget);
      int t = 0;
      do begin
         @(negedge clk);
         #2;
         t++;
      end while ((busy || res_valid || exp_q.size() != 0) && t < budget);
      check("drain_queue", exp_q.size(), 0);
      check("drain_busy", busy, 0);
   endtask

   // Serial-unit stub: done_in SERIAL_LAT (or TIMEOUT) cycles after s, or never.
   initial begin
      logic [W-1:0] a, b;
      int           mode, lat, gen;
      bit           stable;
      forever begin
         @(negedge clk);
         if (s === 1'b1 && !reset) begin
            a      = Ain;
            b      = Bin;
            gen    = rst_gen;
            mode   = (mode_q.size() > 0) ? mode_q.pop_front() : M_NORM;
            lat    = (mode == M_EXACT) ? TO : SERIAL_LAT;
            stable = 1'b1;
            for (int i = 1; i <= lat; i++) begin
               @(negedge clk);
               if (Ain !== a || Bin !== b || s !== 1'b0) stable = 1'b0;
            end
            if (mode != M_NEVER) begin
               done_in = 1'b1;
               C_in    = stub_c(a, b);
            end
            @(negedge clk);
            done_in = 1'b0;
            C_in    = '0;
            #1;
            if (gen == rst_gen) begin
               check("ain_bin_stable", stable, 1);
               if (mode != M_NEVER) begin
                  check("res_valid_after_done", res_valid, 1);
                  check("res_data_after_done", res_data, stub_c(a, b));
               end
            end
         end
      end
   end

   // Result monitor: every handshake must match the oldest expected result.
   initial begin
      forever begin
         @(negedge clk);
         #1;
         if (res_valid === 1'b1 && res_ready === 1'b1 && !reset) begin
            check("res_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) check("res_data", res_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, n_fail %0d", n_fail);
      $fatal(1, "global timeout");
   end

   initial begin
      int           t;
      bit           ok;
      logic [W-1:0] held, ra, rb;

      repeat (3) @(negedge clk);
      check("rst_s", s, 0);
      check("rst_ain", Ain, 0);
      check("rst_bin", Bin, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_res_data", res_data, 0);
      check("rst_busy", busy, 0);
      check("rst_terr", timeout_err, 0);
      check("rst_in_ready", in_ready, 1);
`ifdef ISSUER_STATS_EN
      check("rst_op_count", op_count, 0);
      check("rst_to_count", timeout_count, 0);
`endif
      reset = 1'b0;

      // Single op: s two edges after accept, operands on Ain/Bin.
      push(4'hA, 4'h6, 1);
      @(negedge clk);
      check("issue_s_early", s, 0);
      @(negedge clk);
      check("issue_s", s, 1);
      check("issue_ain", Ain, 4'hA);
      check("issue_bin", Bin, 4'h6);
      check("issue_busy", busy, 1);
      wait_idle(60);

      // done_in on the last watchdog cycle still completes cleanly.
      mode_q.push_back(M_EXACT);
      push(4'h3, 4'h5, 1);
      wait_idle(80);
      check("exact_no_terr", timeout_err, 0);

      // Back-pressure: one pair in flight plus DEPTH queued fills the FIFO.
      for (int i = 0; i < 5; i++) begin
         ra = W'($urandom_range(0, 15));
         rb = W'($urandom_range(0, 15));
         push(ra, rb, 1);
      end
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      push(4'hF, 4'h1, 1);
      wait_idle(300);

      // Result held while res_ready is low; next issue one IDLE cycle after release.
      res_ready = 1'b0;
      push(4'h9, 4'h2, 1);
      push(4'h4, 4'hC, 1);
      t = 0;
      while (res_valid !== 1'b1 && t < 60) begin
         @(negedge clk);
         t++;
      end
      check("hold_valid", res_valid, 1);
      held = res_data;
      ok   = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (res_valid !== 1'b1 || res_data !== held || s !== 1'b0) ok = 1'b0;
      end
      check("hold_stable", ok, 1);
      res_ready = 1'b1;
      @(negedge clk);
      check("hold_gap_s", s, 0);
      check("hold_gap_valid", res_valid, 0);
      @(negedge clk);
      check("hold_next_s", s, 1);
      check("hold_next_ain", Ain, 4'h4);
      wait_idle(80);

      // Watchdog abort, then the queued pair issues.
      mode_q.push_back(M_NEVER);
      push(4'h1, 4'h2, 0);
      push(4'h7, 4'h8, 1);
      wait_s(20);
      repeat (TO) @(negedge clk);
      check("to_terr_before", timeout_err, 0);
      check("to_busy_before", busy, 1);
      @(negedge clk);
      check("to_terr", timeout_err, 1);
      check("to_busy_after", busy, 0);
      @(negedge clk);
      check("to_next_s", s, 1);
      check("to_next_ain", Ain, 4'h7);
      wait_idle(80);
      check("to_sticky", timeout_err, 1);

      // Reset mid-WAIT with two pairs queued; the stub's late done_in must be ignored.
      push(4'h5, 4'h5, 0);
      push(4'h6, 4'h1, 0);
      push(4'hE, 4'h3, 0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      rst_gen++;
      @(negedge clk);
      check("mid_rst_s", s, 0);
      check("mid_rst_ain", Ain, 0);
      check("mid_rst_bin", Bin, 0);
      check("mid_rst_res_valid", res_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_terr", timeout_err, 0);
      check("mid_rst_in_ready", in_ready, 1);
      reset = 1'b0;
      ok = 1'b1;
      repeat (25) begin
         @(negedge clk);
         if (res_valid !== 1'b0 || busy !== 1'b0 || s !== 1'b0) ok = 1'b0;
      end
      check("mid_rst_quiet", ok, 1);

      // One abort followed by three completions.
      mode_q.push_back(M_NEVER);
      push(4'h2, 4'h2, 0);
      push(4'h1, 4'h8, 1);
      push(4'hC, 4'h3, 1);
      push(4'h0, 4'hF, 1);
      wait_idle(250);
      check("final_terr", timeout_err, 1);
`ifdef ISSUER_STATS_EN
      check("stat_op_count", op_count, 3);
      check("stat_to_count", timeout_count, 1);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
